// File: rtl/sdc_pkg.sv
// Shared types and sizing for the sdc_* sector-read responder.
package sdc_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SDC_LBA_W    = 11;
    localparam int unsigned SDC_OFS_W    = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PUSH,
        DONE,
        HOLD
    } sdc_state_t;

endpackage

// File: rtl/sdc_byte_fetch.sv
// Single-byte fetch from the image store: mem_req/mem_ack handshake or zero-fill.
// byte_valid is combinational so a zero-fill byte is available in the start cycle.
module sdc_byte_fetch #(
    parameter int unsigned MEM_AW = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              zero_fill,
    input  logic [MEM_AW-1:0] addr,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data
);

    logic              mem_req_q,  mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // An ack only counts while a request is outstanding, so a stray ack after reset is dropped.
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        byte_valid = 1'b0;
        byte_data  = '0;
        if (start && zero_fill) begin
            byte_valid = 1'b1;
        end else if (start) begin
            mem_req_d  = 1'b1;
            mem_addr_d = addr;
        end
        if (mem_req_q && mem_ack) begin
            mem_req_d  = 1'b0;
            byte_valid = 1'b1;
            byte_data  = mem_data;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: rtl/sdc_sector_responder.sv
// Responder for chipset sdc_* sector reads: streams 512 bytes from the image store.
// Optional SDC_BOUNDS_CHECK_EN zero-fills sectors lying past image_size.
module sdc_sector_responder
    import sdc_pkg::*;
#(
    parameter int unsigned       MEM_AW    = 22,
    parameter logic [MEM_AW-1:0] IMG_BASE0 = MEM_AW'(22'h000000),
    parameter logic [MEM_AW-1:0] IMG_BASE1 = MEM_AW'(22'h200000)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           image_mounted,
    input  logic [31:0]          image_size,
    input  logic [1:0]           sdc_rd,
    input  logic [SDC_LBA_W-1:0] sdc_lba,
    output logic                 sdc_busy,
    output logic                 sdc_done,
    output logic [7:0]           sdc_data,
    output logic                 sdc_data_en,
    output logic [SDC_OFS_W-1:0] sdc_addr,
    output logic                 mem_req,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data
);

    sdc_state_t           state_q,  state_d;
    logic                 drive_q,  drive_d;
    logic [SDC_LBA_W-1:0] lba_q,    lba_d;
    logic [SDC_OFS_W-1:0] offset_q, offset_d;
    logic [7:0]           data_q,   data_d;

    logic                 fetch_start;
    logic                 zero_fill;
    logic                 out_of_bounds;
    logic [MEM_AW-1:0]    fetch_addr;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 last_byte;

    assign fetch_addr = (drive_q ? IMG_BASE1 : IMG_BASE0) + MEM_AW'({lba_q, offset_q});
    assign last_byte  = (offset_q == SDC_OFS_W'(SECTOR_BYTES - 1));

`ifdef SDC_BOUNDS_CHECK_EN
    logic [32:0] sector_end;
    assign sector_end    = 33'({lba_q, {SDC_OFS_W{1'b0}}}) + 33'(SECTOR_BYTES);
    assign out_of_bounds = (sector_end > {1'b0, image_size});
`else
    logic unused_image_size;
    assign unused_image_size = ^image_size;
    assign out_of_bounds     = 1'b0;
`endif

    assign zero_fill   = !image_mounted[drive_q] || out_of_bounds;
    assign fetch_start = (state_q == FETCH);

    sdc_byte_fetch #(
        .MEM_AW(MEM_AW)
    ) u_byte_fetch (
        .clk        (clk),
        .reset      (reset),
        .start      (fetch_start),
        .zero_fill  (zero_fill),
        .addr       (fetch_addr),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            drive_q  <= 1'b0;
            lba_q    <= '0;
            offset_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            drive_q  <= drive_d;
            lba_q    <= lba_d;
            offset_q <= offset_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drive_d  = drive_q;
        lba_d    = lba_q;
        offset_d = offset_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (|sdc_rd) begin
                    drive_d  = !sdc_rd[0];
                    lba_d    = sdc_lba;
                    offset_d = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (byte_valid) begin
                    data_d  = byte_data;
                    state_d = PUSH;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (byte_valid) begin
                    data_d  = byte_data;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    offset_d = offset_q + 1'b1;
                    state_d  = FETCH;
                end
            end
            DONE: state_d = HOLD;
            // Release on the served drive's bit only, so a still-pending drive 1 follows drive 0.
            HOLD: begin
                if (!sdc_rd[drive_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sdc_busy    = (state_q == FETCH) || (state_q == WAIT) || (state_q == PUSH);
        sdc_done    = (state_q == DONE);
        sdc_data_en = (state_q == PUSH);
        sdc_data    = data_q;
        sdc_addr    = offset_q;
    end

endmodule

// File: tb/tb_sdc_sector_responder.sv
// Self-checking bench for sdc_sector_responder against a byte-level sector model.
module tb_sdc_sector_responder;

    localparam logic [21:0] BASE0 = 22'h000000;
    localparam logic [21:0] BASE1 = 22'h200000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  image_mounted;
    logic [31:0] image_size;
    logic [1:0]  sdc_rd;
    logic [10:0] sdc_lba;
    logic        sdc_busy, sdc_done, sdc_data_en;
    logic [7:0]  sdc_data;
    logic [8:0]  sdc_addr;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack  = 1'b0;
    logic [7:0]  mem_data = 8'h00;

    always #5 clk = ~clk;

    sdc_sector_responder #(
        .MEM_AW    (22),
        .IMG_BASE0 (BASE0),
        .IMG_BASE1 (BASE1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .image_mounted (image_mounted),
        .image_size    (image_size),
        .sdc_rd        (sdc_rd),
        .sdc_lba       (sdc_lba),
        .sdc_busy      (sdc_busy),
        .sdc_done      (sdc_done),
        .sdc_data      (sdc_data),
        .sdc_data_en   (sdc_data_en),
        .sdc_addr      (sdc_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data)
    );

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Observation records, written only by the monitor / responder below.
    int unsigned cyc = 0;
    logic [8:0]  s_addr[$];
    logic [7:0]  s_data[$];
    int unsigned s_cyc[$];
    logic [21:0] req_log[$];
    int unsigned done_n = 0;
    int unsigned done_cyc = 0;
    int unsigned req_cycles = 0;

    // Responder controls, written only by the main initial block.
    int unsigned max_lat  = 0;
    bit          hold_ack = 1'b0;
    bit          late_ack = 1'b0;

    function automatic logic [7:0] mem_fn(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    function automatic logic [21:0] exp_addr(input bit drv, input int unsigned lba, input int unsigned ofs);
        longint unsigned a;
        a = longint'(drv ? BASE1 : BASE0) + longint'(lba) * 512 + longint'(ofs);
        return 22'(a);
    endfunction

    // Offset from which the sector reads as zeros (512 = fully fetched).
    function automatic int unsigned zero_from(input bit drv, input logic [1:0] mnt,
                                              input int unsigned lba, input logic [31:0] size);
        bit oob;
        oob = (longint'(lba) * 512 + 512) > longint'(size);
`ifndef SDC_BOUNDS_CHECK_EN
        oob = 1'b0;
`endif
        if (!mnt[drv] || oob) return 0;
        return 512;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (sdc_data_en) begin
            s_addr.push_back(sdc_addr);
            s_data.push_back(sdc_data);
            s_cyc.push_back(cyc);
        end
        if (sdc_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (mem_req) req_cycles++;
    end

    bit          pending = 1'b0;
    int unsigned lat_cnt = 0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (reset) begin
            pending = 1'b0;
        end else if (mem_req && !hold_ack) begin
            if (!pending) begin
                pending = 1'b1;
                lat_cnt = $urandom_range(max_lat, 0);
                req_log.push_back(mem_addr);
            end
            if (lat_cnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = mem_fn(mem_addr);
                pending  = 1'b0;
            end else begin
                lat_cnt--;
            end
        end else if (!mem_req && late_ack) begin
            mem_ack  = 1'b1;
            mem_data = 8'hA5;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},    32'(sdc_busy),    0);
        check({tag, " done"},    32'(sdc_done),    0);
        check({tag, " data_en"}, 32'(sdc_data_en), 0);
        check({tag, " data"},    32'(sdc_data),    0);
        check({tag, " addr"},    32'(sdc_addr),    0);
        check({tag, " mem_req"}, 32'(mem_req),     0);
        check({tag, " mem_addr"},32'(mem_addr),    0);
    endtask

    task automatic wait_done(input string tag, input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (done_n < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, " done_seen"}, 32'(done_n >= target), 1);
    endtask

    task automatic check_sector(input string tag, input bit drv, input int unsigned lba,
                                input int unsigned zf, input int unsigned s0, input int unsigned r0);
        logic [7:0] exp_b;
        check({tag, " nbytes"}, 32'(s_addr.size() - s0), 512);
        check({tag, " nreq"},   32'(req_log.size() - r0), 32'(zf));
        if (s_addr.size() - s0 >= 512) begin
            for (int i = 0; i < 512; i++) begin
                exp_b = (i < int'(zf)) ? mem_fn(exp_addr(drv, lba, i)) : 8'h00;
                check($sformatf("%s addr[%0d]", tag, i), 32'(s_addr[s0 + i]), 32'(i));
                check($sformatf("%s data[%0d]", tag, i), 32'(s_data[s0 + i]), 32'(exp_b));
            end
        end
        if (req_log.size() - r0 >= zf) begin
            for (int i = 0; i < int'(zf); i++)
                check($sformatf("%s mem_addr[%0d]", tag, i), 32'(req_log[r0 + i]),
                      32'(exp_addr(drv, lba, i)));
        end
    endtask

    task automatic run_sector(input string tag, input logic [1:0] rd, input int unsigned lba);
        int unsigned s0 = s_addr.size();
        int unsigned r0 = req_log.size();
        int unsigned d0 = done_n;
        int unsigned q0 = req_cycles;
        int unsigned c0;
        bit drv = !rd[0];
        int unsigned zf = zero_from(drv, image_mounted, lba, image_size);
        sdc_lba = 11'(lba);
        sdc_rd  = rd;
        c0 = cyc;
        wait_done(tag, d0 + 1, 6000);
        check({tag, " busy_at_done"}, 32'(sdc_busy), 0);
        check_sector(tag, drv, lba, zf, s0, r0);
        if (zf == 0) begin
            check({tag, " no_mem_req"}, 32'(req_cycles - q0), 0);
            check({tag, " zero_fill_time"}, 32'(done_cyc - c0 >= 1024), 1);
        end else if (s_cyc.size() > s0) begin
            check({tag, " first_latency"}, 32'(s_cyc[s0] - c0 >= 3), 1);
        end
        repeat (10) tick();
        check({tag, " single_service"}, 32'(done_n - d0), 1);
        check({tag, " no_extra_bytes"}, 32'(s_addr.size() - s0), 512);
        sdc_rd = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        int unsigned s0, r0, d0, q0, lba_a, lba_b;

        reset         = 1'b1;
        image_mounted = 2'b00;
        image_size    = 32'hFFFF_FFFF;
        sdc_rd        = 2'b00;
        sdc_lba       = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic drive-0 sector with single-cycle memory.
        image_mounted = 2'b11;
        max_lat = 0;
        run_sector("t1_d0_lba0", 2'b01, 0);

        // Drive-1 address arithmetic, variable memory latency.
        max_lat = 2;
        r0 = req_log.size();
        run_sector("t2_d1_lba3", 2'b10, 3);
        if (req_log.size() - r0 >= 512) begin
            check("t2 first_addr", 32'(req_log[r0]), 32'h200600);
            check("t2 last_addr",  32'(req_log[r0 + 511]), 32'h2007FF);
        end

        // Simultaneous requests: drive 0 first, then drive 1 once bit0 drops.
        max_lat = 1;
        lba_a = $urandom_range(2047, 0);
        lba_b = $urandom_range(2047, 0);
        s0 = s_addr.size(); r0 = req_log.size(); d0 = done_n;
        sdc_lba = 11'(lba_a);
        sdc_rd  = 2'b11;
        wait_done("t3_first", d0 + 1, 6000);
        check_sector("t3_d0", 1'b0, lba_a, 512, s0, r0);
        s0 = s_addr.size(); r0 = req_log.size();
        sdc_lba = 11'(lba_b);
        sdc_rd  = 2'b10;
        wait_done("t3_second", d0 + 2, 6000);
        check_sector("t3_d1", 1'b1, lba_b, 512, s0, r0);
        sdc_rd = 2'b00;
        repeat (10) tick();
        check("t3 done_pulses", 32'(done_n - d0), 2);

        // Unmounted drive: zero sector, no memory traffic.
        image_mounted = 2'b00;
        run_sector("t4_unmounted", 2'b01, $urandom_range(2047, 0));
        image_mounted = 2'b11;

        // Reset while byte 100's request is outstanding.
        max_lat = 1;
        lba_a = $urandom_range(2047, 0);
        s0 = s_addr.size();
        sdc_lba = 11'(lba_a);
        sdc_rd  = 2'b01;
        for (int n = 0; n < 2000 && s_addr.size() - s0 < 100; n++) tick();
        hold_ack = 1'b1;
        for (int n = 0; n < 10 && !mem_req; n++) tick();
        check("t5 mem_req_held", 32'(mem_req), 1);
        check("t5 byte100_addr", 32'(mem_addr), 32'(exp_addr(1'b0, lba_a, 100)));
        reset  = 1'b1;
        sdc_rd = 2'b00;
        #1;
        check_idle_outputs("t5_reset");
        repeat (2) tick();
        reset    = 1'b0;
        hold_ack = 1'b0;
        s0 = s_addr.size(); q0 = req_cycles; d0 = done_n;
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        repeat (5) tick();
        check("t5 late_ack_busy",   32'(sdc_busy), 0);
        check("t5 late_ack_req",    32'(req_cycles - q0), 0);
        check("t5 late_ack_bytes",  32'(s_addr.size() - s0), 0);
        check("t5 late_ack_done",   32'(done_n - d0), 0);
        run_sector("t5_restart", 2'b01, $urandom_range(2047, 0));

        // Image bounds: sector ending exactly at image_size, and one past it.
        image_size = 32'd1024;
        run_sector("t6_lba1_edge", 2'b01, 1);
        r0 = req_log.size();
        run_sector("t6_lba2_past", 2'b01, 2);
`ifndef SDC_BOUNDS_CHECK_EN
        if (req_log.size() > r0) check("t6 fetch_0x400", 32'(req_log[r0]), 32'h400);
`endif

        // Drop sdc_rd mid-sector, then unmount: transfer completes, tail zero-filled.
        image_size = 32'hFFFF_FFFF;
        lba_a = $urandom_range(2047, 0);
        s0 = s_addr.size(); r0 = req_log.size(); d0 = done_n;
        sdc_lba = 11'(lba_a);
        sdc_rd  = 2'b01;
        for (int n = 0; n < 2000 && s_addr.size() - s0 < 50; n++) tick();
        sdc_rd = 2'b00;
        for (int n = 0; n < 4000 && s_addr.size() - s0 < 200; n++) tick();
        image_mounted = 2'b10;
        wait_done("t8", d0 + 1, 6000);
        check_sector("t8_unmount", 1'b0, lba_a, 200, s0, r0);
        repeat (3) tick();
        image_mounted = 2'b11;

        // Randomized sectors across drives, mounts, sizes and latencies.
        for (int k = 0; k < 3; k++) begin
            max_lat       = $urandom_range(2, 0);
            lba_a         = $urandom_range(2047, 0);
            image_mounted = 2'($urandom_range(3, 0));
            image_size    = lba_a * 512 + $urandom_range(1024, 0);
            run_sector($sformatf("t7_rand%0d", k), ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10, lba_a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
